// File: rtl/alu_seq_multiplier_if.sv
// Handshake and data bundle between the execute stage and the sequential multiplier.
// The master side requests a multiply; the slave side (the multiplier) answers with the product.
interface alu_seq_multiplier_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   logic                 overflow;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product, overflow
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product, overflow
   );
endinterface

// File: rtl/alu_seq_multiplier.sv
// Sequential unsigned shift-add multiplier for the ALU MULT operation.
// One conditional add-and-shift per clock; WIDTH iterations give a 2*WIDTH product,
// followed by a single-cycle done pulse and an unsigned overflow flag.
module alu_seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_seq_multiplier_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH:0]     acc_q, acc_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 overflow_q, overflow_d;

   logic [WIDTH:0]       upper_sum;
   logic [2*WIDTH:0]     acc_step;

   // One iteration: conditionally add the multiplicand into the upper field (carry kept in the
   // extra top bit), then shift the whole accumulator right so the carry lands in the product.
   always_comb begin
      upper_sum = acc_q[2*WIDTH:WIDTH];
      if (acc_q[0]) begin
         upper_sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
      end
      acc_step = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
   end

   // Next-state and next-output logic; every output is taken from a flop so nothing
   // combinational reaches the ports.
   always_comb begin
      state_d    = state_q;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      count_d    = count_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      product_d  = product_q;
      overflow_d = overflow_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d = bus.multiplicand;
               acc_d   = {1'b0, {WIDTH{1'b0}}, bus.multiplier};
               count_d = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d      = acc_step;
            count_d    = count_q + CW'(1);
            product_d  = acc_step[2*WIDTH-1:0];
            overflow_d = |acc_step[2*WIDTH-1:WIDTH];
            if (count_q == CW'(WIDTH - 1)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State register; a synchronous reset aborts any multiply in flight and clears the result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         mcand_q    <= '0;
         acc_q      <= '0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         product_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         product_q  <= product_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.product  = product_q;
   assign bus.overflow = overflow_q;

endmodule
